// File: rtl/seq_divider_if.sv
// ============================================================================
// Module  : seq_divider_if
// Brief   : EX-stage <-> sequential divider request/response bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic                 div_en;
  logic                 signed_div;
  logic                 cancel;
  logic [WIDTH-1:0]     operand_1;
  logic [WIDTH-1:0]     operand_2;
  logic                 done;
  logic                 busy;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output div_en, signed_div, cancel, operand_1, operand_2,
    input  done, busy, result
  );

  modport slave (
    input  div_en, signed_div, cancel, operand_1, operand_2,
    output done, busy, result
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module  : seq_divider
// Brief   : Multi-cycle restoring divider, signed/unsigned, {rem, quo} result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [1:0]      S_IDLE = 2'd0;
  localparam logic [1:0]      S_BUSY = 2'd1;
  localparam logic [1:0]      S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [WIDTH-1:0]   quo_q,    quo_d;
  logic [WIDTH-1:0]   rem_q,    rem_d;
  logic [WIDTH-1:0]   op1_q,    op1_d;
  logic [WIDTH-1:0]   op2_q,    op2_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               start;
  logic               last_step;
  logic [WIDTH-1:0]   dvsr_mag;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               step_fits;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic               quo_neg;
  logic               rem_neg;
  logic               done;
  logic               busy;

  function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  assign start     = (state_q == S_IDLE) && bus.div_en && !bus.cancel;
  assign last_step = (count_q == LAST);

  // Magnitude of the most negative value wraps to itself, which reads
  // correctly as an unsigned magnitude.
  assign dvsr_mag  = negate_if(op2_q, signed_q & op2_q[WIDTH-1]);
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr_mag};
  assign step_fits = !rem_diff[WIDTH];
  assign rem_step  = step_fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], step_fits};
  assign quo_neg   = signed_q & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
  assign rem_neg   = signed_q & op1_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      signed_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      signed_q <= signed_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (bus.operand_2 == '0) ? S_DONE : S_BUSY;
      S_BUSY:  if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.cancel) state_d = S_IDLE;
  end

  always_comb begin
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    signed_d = signed_q;
    result_d = result_q;
    if (start) begin
      op1_d    = bus.operand_1;
      op2_d    = bus.operand_2;
      signed_d = bus.signed_div;
      quo_d    = negate_if(bus.operand_1, bus.signed_div & bus.operand_1[WIDTH-1]);
      rem_d    = '0;
      count_d  = '0;
      if (bus.operand_2 == '0) result_d = {bus.operand_1, {WIDTH{1'b1}}};
    end else if (state_q == S_BUSY && !bus.cancel) begin
      quo_d   = quo_step;
      rem_d   = rem_step;
      count_d = count_q + CW'(1);
      if (last_step) result_d = {negate_if(rem_step, rem_neg), negate_if(quo_step, quo_neg)};
    end
  end

  always_comb begin
    done = (state_q == S_DONE) && !bus.cancel;
    busy = (state_q == S_BUSY);
  end

  assign bus.done   = done;
  assign bus.busy   = busy;
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module  : tb_seq_divider
// Brief   : Random + directed bench for seq_divider against an arithmetic model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] last_res = '0;
  logic [63:0] res;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      ma, mb, q, r;
    logic [63:0] q64, r64;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      ma = longint'($signed(a));
      mb = longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'({32'd0, a});
      mb = longint'({32'd0, b});
    end
    q = ma / mb;
    r = ma % mb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    q64 = q;
    r64 = r;
    return {r64[31:0], q64[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 20));
      3:       return 32'($signed(-$urandom_range(1, 20)));
      default: return 32'($urandom);
    endcase
  endfunction

  // One isolated division; operands are scrambled right after the start edge.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] got);
    logic [63:0] exp_res;
    int unsigned t0;
    bit          seen;
    int          exp_lat;
    exp_res = model(a, b, s);
    exp_lat = (b == 32'd0) ? 1 : W + 1;
    got     = '0;
    @(negedge clk);
    bus.div_en = 1'b1; bus.operand_1 = a; bus.operand_2 = b; bus.signed_div = s;
    t0   = cyc + 1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.div_en     = 1'b0;
        bus.operand_1  = $urandom;
        bus.operand_2  = $urandom;
        bus.signed_div = 1'($urandom);
      end
      if (i == 4 && b != 32'd0) begin
        check_eq("busy", 64'(bus.busy), 64'd1);
        check_eq("hold", bus.result, last_res);
      end
      if (bus.done) begin
        seen = 1'b1;
        got  = bus.result;
        check_eq("latency", 64'(int'(cyc - t0) + 1), 64'(exp_lat));
        check_eq("result", bus.result, exp_res);
      end
    end
    check_eq("done_seen", 64'(seen), 64'd1);
    last_res = exp_res;
    @(negedge clk);
    check_eq("pulse_width", 64'(bus.done), 64'd0);
  endtask

  task automatic run_abort(input bit use_rst);
    int pulses;
    @(negedge clk);
    bus.div_en = 1'b1; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7; bus.signed_div = 1'b0;
    @(negedge clk);
    bus.div_en = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("abort_busy_before", 64'(bus.busy), 64'd1);
    if (use_rst) rst = 1'b1; else bus.cancel = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.cancel = 1'b0;
    check_eq("abort_idle", 64'(bus.busy), 64'd0);
    if (use_rst) last_res = '0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_eq("abort_no_done", 64'(pulses), 64'd0);
    check_eq("abort_result", bus.result, last_res);
  endtask

  initial begin
    int          d1, d2, lat;
    logic        b34, b35;
    logic [63:0] r1, r2;
    int unsigned t0;
    logic [31:0] a, b;
    logic        s;

    rst = 1'b1;
    bus.div_en = 1'b0; bus.cancel = 1'b0; bus.signed_div = 1'b0;
    bus.operand_1 = '0; bus.operand_2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_result", bus.result, 64'd0);
    rst = 1'b0;

    run_div(32'd7, 32'd2, 1'b0, res);
    check_eq("udiv_7_2", res, 64'h00000001_00000003);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, res);
    check_eq("sdiv_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, res);
    check_eq("sdiv_7_m2", res, 64'h00000001_FFFFFFFD);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res);
    check_eq("sdiv_min_m1", res, 64'h00000000_80000000);
    run_div(32'h1234_5678, 32'd0, 1'b0, res);
    check_eq("div_zero", res, 64'h12345678_FFFFFFFF);

    // Back-to-back with div_en held the whole time.
    @(negedge clk);
    bus.div_en = 1'b1; bus.operand_1 = 32'd100; bus.operand_2 = 32'd7; bus.signed_div = 1'b0;
    t0 = cyc + 1;
    d1 = -1; d2 = -1; b34 = 1'b1; b35 = 1'b0; r1 = '0; r2 = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      lat = int'(cyc - t0) + 1;
      if (lat == 34) b34 = bus.busy;
      if (lat == 35) b35 = bus.busy;
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = lat; r1 = bus.result;
          bus.operand_1 = 32'hFFFF_FFFF; bus.operand_2 = 32'h10;
        end else if (d2 < 0) begin
          d2 = lat; r2 = bus.result;
          bus.div_en = 1'b0;
        end
      end
    end
    bus.div_en = 1'b0;
    check_eq("b2b_done1", 64'(d1), 64'd33);
    check_eq("b2b_res1", r1, 64'h00000002_0000000E);
    check_eq("b2b_idle34", 64'(b34), 64'd0);
    check_eq("b2b_busy35", 64'(b35), 64'd1);
    check_eq("b2b_done2", 64'(d2), 64'd67);
    check_eq("b2b_res2", r2, 64'h0000000F_0FFFFFFF);
    last_res = 64'h0000000F_0FFFFFFF;

    run_abort(1'b0);
    run_div(32'd9, 32'd3, 1'b0, res);
    check_eq("after_cancel", res, 64'h00000000_00000003);
    run_abort(1'b1);
    run_div(32'd9, 32'd3, 1'b0, res);
    check_eq("after_rst", res, 64'h00000000_00000003);

    for (int i = 0; i < 50; i++) begin
      a = pick();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      s = 1'($urandom);
      run_div(a, b, s, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
